// File: rtl/cr_fifo_rr_arb_if.sv
// Bundle for cr_fifo_rr_arb: FIFO-side pop handshake and the shared output stream.
// master = arbiter, slave = FIFO bank plus downstream consumer.
interface cr_fifo_rr_arb_if #(
   parameter int N_REQ       = 4,
   parameter int N_DATA_BITS = 64
);
   localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]             fifo_empty;
   logic [N_REQ*N_DATA_BITS-1:0] fifo_rdata;
   logic [N_REQ-1:0]             fifo_ren;
   logic                         out_valid;
   logic [N_DATA_BITS-1:0]       out_data;
   logic [SRC_W-1:0]             out_src;
   logic                         out_ready;
   logic                         busy;

   modport master (
      input  fifo_empty, fifo_rdata, out_ready,
      output fifo_ren, out_valid, out_data, out_src, busy
   );

   modport slave (
      output fifo_empty, fifo_rdata, out_ready,
      input  fifo_ren, out_valid, out_data, out_src, busy
   );
endinterface

// File: rtl/cr_fifo_rr_arb.sv
// Burst-limited round-robin drain of N_REQ show-ahead FIFOs into one registered stream.
// Optional counters (stall_cnt, pop_cnt, stats_clr) under `CR_FIFO_RR_ARB_STATS_EN.
module cr_fifo_rr_arb #(
   parameter int N_REQ       = 4,
   parameter int N_DATA_BITS = 64,
   parameter int MAX_BURST   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cr_fifo_rr_arb_if.master     bus
`ifdef CR_FIFO_RR_ARB_STATS_EN
   ,
   input  logic                 stats_clr,
   output logic [15:0]          stall_cnt,
   output logic [N_REQ*16-1:0]  pop_cnt
`endif
);
   localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                 state;
   logic [SRC_W-1:0]       grant;
   logic [SRC_W-1:0]       last;
   logic [7:0]             burst_cnt;
   logic                   slot_free;
   logic                   pop;
   logic                   hi_found, lo_found, arb_found;
   logic [SRC_W-1:0]       hi_idx, lo_idx, arb_idx;
   logic [N_DATA_BITS-1:0] head [N_REQ];

   always_comb begin
      for (int unsigned i = 0; i < N_REQ; i++)
         head[i] = bus.fifo_rdata[i*N_DATA_BITS +: N_DATA_BITS];
   end

   // Rotating priority: first non-empty above last wins, else first at or below it.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_found = 1'b0;
      lo_idx   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!bus.fifo_empty[i]) begin
            if (i > 32'(last)) begin
               if (!hi_found) begin
                  hi_found = 1'b1;
                  hi_idx   = SRC_W'(i);
               end
            end else if (!lo_found) begin
               lo_found = 1'b1;
               lo_idx   = SRC_W'(i);
            end
         end
      end
      arb_found = hi_found | lo_found;
      arb_idx   = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      slot_free = ~bus.out_valid | bus.out_ready;
      pop       = (state == BURST) & ~bus.fifo_empty[grant] & slot_free;
      bus.fifo_ren = '0;
      if (pop)
         bus.fifo_ren[grant] = 1'b1;
      bus.busy = (state == BURST) | bus.out_valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         grant         <= '0;
         last          <= SRC_W'(N_REQ - 1);
         burst_cnt     <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_src   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_found) begin
                  grant     <= arb_idx;
                  burst_cnt <= '0;
                  state     <= BURST;
               end
            end
            BURST: begin
               if (pop)
                  burst_cnt <= burst_cnt + 8'd1;
               if (bus.fifo_empty[grant] || (pop && burst_cnt == BURST_LAST)) begin
                  state <= IDLE;
                  last  <= grant;
               end
            end
            default: state <= IDLE;
         endcase

         // A pop refills the slot even while the old entry is leaving.
         if (pop) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= head[grant];
            bus.out_src   <= grant;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end

`ifdef CR_FIFO_RR_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         pop_cnt   <= '0;
      end else if (stats_clr) begin
         stall_cnt <= '0;
         pop_cnt   <= '0;
      end else begin
         if (bus.out_valid && !bus.out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (bus.fifo_ren[i] && pop_cnt[i*16 +: 16] != 16'hFFFF)
               pop_cnt[i*16 +: 16] <= pop_cnt[i*16 +: 16] + 16'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_cr_fifo_rr_arb.sv
// Directed bench for cr_fifo_rr_arb: MAX_BURST=4 instance (a) and MAX_BURST=1 instance (b).
module tb_cr_fifo_rr_arb;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   cr_fifo_rr_arb_if #(.N_REQ(4), .N_DATA_BITS(64)) ifa ();
   cr_fifo_rr_arb_if #(.N_REQ(4), .N_DATA_BITS(64)) ifb ();

`ifdef CR_FIFO_RR_ARB_STATS_EN
   logic        clr_a, clr_b;
   logic [15:0] stall_a, stall_b;
   logic [63:0] popc_a, popc_b;
`endif

   cr_fifo_rr_arb #(.N_REQ(4), .N_DATA_BITS(64), .MAX_BURST(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa)
`ifdef CR_FIFO_RR_ARB_STATS_EN
      , .stats_clr(clr_a), .stall_cnt(stall_a), .pop_cnt(popc_a)
`endif
   );

   cr_fifo_rr_arb #(.N_REQ(4), .N_DATA_BITS(64), .MAX_BURST(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb)
`ifdef CR_FIFO_RR_ARB_STATS_EN
      , .stats_clr(clr_b), .stall_cnt(stall_b), .pop_cnt(popc_b)
`endif
   );

   // Show-ahead FIFO models: wp owned by the stimulus, rp by the pop process.
   logic [63:0] mem_a [4][64];
   logic [63:0] mem_b [4][64];
   logic [5:0]  wp_a [4];
   logic [5:0]  wp_b [4];
   logic [5:0]  rp_a [4] = '{default: 6'd0};
   logic [5:0]  rp_b [4] = '{default: 6'd0};

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         ifa.fifo_empty[i]        = (wp_a[i] == rp_a[i]);
         ifa.fifo_rdata[i*64 +: 64] = mem_a[i][rp_a[i]];
         ifb.fifo_empty[i]        = (wp_b[i] == rp_b[i]);
         ifb.fifo_rdata[i*64 +: 64] = mem_b[i][rp_b[i]];
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ifa.fifo_ren[i]) rp_a[i] <= rp_a[i] + 6'd1;
         if (ifb.fifo_ren[i]) rp_b[i] <= rp_b[i] + 6'd1;
      end
   end

   typedef struct {
      logic        rdy;
      logic [3:0]  ren;
      logic        vld;
      logic [63:0] data;
      logic [1:0]  src;
      logic        busy;
   } vec_t;

   vec_t tv_burst [11];
   vec_t tv_stall [11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_a(input logic [1:0] f, input logic [63:0] d);
      mem_a[f][wp_a[f]] = d;
      wp_a[f] = wp_a[f] + 6'd1;
   endtask

   task automatic push_b(input logic [1:0] f, input logic [63:0] d);
      mem_b[f][wp_b[f]] = d;
      wp_b[f] = wp_b[f] + 6'd1;
   endtask

   task automatic apply(input vec_t v, input string tag);
      ifa.out_ready = v.rdy;
      #1;
      chk({tag, ".ren"},  64'(ifa.fifo_ren),  64'(v.ren));
      chk({tag, ".vld"},  64'(ifa.out_valid), 64'(v.vld));
      chk({tag, ".data"}, ifa.out_data,        v.data);
      chk({tag, ".src"},  64'(ifa.out_src),   64'(v.src));
      chk({tag, ".busy"}, 64'(ifa.busy),      64'(v.busy));
   endtask

   initial begin
      int          n;
      int          last_cyc;
      logic [63:0] exp_d;
      logic [1:0]  exp_s;

      //               rdy  ren      vld   data      src   busy
      tv_burst[0]  = '{1'b1, 4'b0000, 1'b0, 64'h0,  2'd0, 1'b0};
      tv_burst[1]  = '{1'b1, 4'b0001, 1'b0, 64'h0,  2'd0, 1'b1};
      tv_burst[2]  = '{1'b1, 4'b0001, 1'b1, 64'hA0, 2'd0, 1'b1};
      tv_burst[3]  = '{1'b1, 4'b0001, 1'b1, 64'hA1, 2'd0, 1'b1};
      tv_burst[4]  = '{1'b1, 4'b0001, 1'b1, 64'hA2, 2'd0, 1'b1};
      tv_burst[5]  = '{1'b1, 4'b0000, 1'b1, 64'hA3, 2'd0, 1'b1};
      tv_burst[6]  = '{1'b1, 4'b0001, 1'b0, 64'hA3, 2'd0, 1'b1};
      tv_burst[7]  = '{1'b1, 4'b0001, 1'b1, 64'hA4, 2'd0, 1'b1};
      tv_burst[8]  = '{1'b1, 4'b0000, 1'b1, 64'hA5, 2'd0, 1'b1};
      tv_burst[9]  = '{1'b1, 4'b0000, 1'b0, 64'hA5, 2'd0, 1'b0};
      tv_burst[10] = '{1'b1, 4'b0000, 1'b0, 64'hA5, 2'd0, 1'b0};

      tv_stall[0]  = '{1'b1, 4'b0000, 1'b0, 64'hA5, 2'd0, 1'b0};
      tv_stall[1]  = '{1'b1, 4'b0100, 1'b0, 64'hA5, 2'd0, 1'b1};
      for (int j = 2; j <= 6; j++)
         tv_stall[j] = '{1'b0, 4'b0000, 1'b1, 64'hC0, 2'd2, 1'b1};
      tv_stall[7]  = '{1'b1, 4'b0100, 1'b1, 64'hC0, 2'd2, 1'b1};
      tv_stall[8]  = '{1'b1, 4'b0100, 1'b1, 64'hC1, 2'd2, 1'b1};
      tv_stall[9]  = '{1'b1, 4'b0000, 1'b1, 64'hC2, 2'd2, 1'b1};
      tv_stall[10] = '{1'b1, 4'b0000, 1'b0, 64'hC2, 2'd2, 1'b0};

      for (int i = 0; i < 4; i++) begin
         wp_a[i] = 6'd0;
         wp_b[i] = 6'd0;
      end
      rst_n = 1'b0;
      ifa.out_ready = 1'b1;
      ifb.out_ready = 1'b1;
`ifdef CR_FIFO_RR_ARB_STATS_EN
      clr_a = 1'b0;
      clr_b = 1'b0;
`endif

      // Reset values, then 20 idle cycles with every FIFO empty.
      repeat (3) @(negedge clk);
      chk("rst.ren",  64'(ifa.fifo_ren),  64'h0);
      chk("rst.vld",  64'(ifa.out_valid), 64'h0);
      chk("rst.data", ifa.out_data,        64'h0);
      chk("rst.src",  64'(ifa.out_src),   64'h0);
      chk("rst.busy", 64'(ifa.busy),      64'h0);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("idle.ren_a",  64'(ifa.fifo_ren),  64'h0);
         chk("idle.vld_a",  64'(ifa.out_valid), 64'h0);
         chk("idle.busy_a", 64'(ifa.busy),      64'h0);
         chk("idle.ren_b",  64'(ifb.fifo_ren),  64'h0);
         chk("idle.vld_b",  64'(ifb.out_valid), 64'h0);
         chk("idle.busy_b", 64'(ifb.busy),      64'h0);
      end

      // FIFO0 with 6 entries: burst of 4, one bubble, then the last 2.
      for (int k = 0; k < 6; k++)
         push_a(2'd0, 64'hA0 + 64'(k));
      for (int j = 0; j < 11; j++) begin
         apply(tv_burst[j], $sformatf("burst[%0d]", j));
         @(negedge clk);
      end

      // FIFO2 with 3 entries, downstream stalled 5 cycles after the first pop.
      for (int k = 0; k < 3; k++)
         push_a(2'd2, 64'hC0 + 64'(k));
      for (int j = 0; j < 11; j++) begin
         apply(tv_stall[j], $sformatf("stall[%0d]", j));
         @(negedge clk);
      end

      // MAX_BURST=1 round robin over four FIFOs holding 2 entries each.
      for (int f = 0; f < 4; f++)
         for (int k = 0; k < 2; k++)
            push_b(2'(f), 64'hB000 + 64'(f * 16 + k));
      n = 0;
      last_cyc = 0;
      for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
         #1;
         if (ifb.out_valid) begin
            exp_s = 2'(n % 4);
            exp_d = 64'hB000 + 64'((n % 4) * 16 + n / 4);
            chk($sformatf("rr.src[%0d]", n),  64'(ifb.out_src), 64'(exp_s));
            chk($sformatf("rr.data[%0d]", n), ifb.out_data,      exp_d);
            if (n > 0)
               chk($sformatf("rr.gap[%0d]", n), 64'(cyc - last_cyc), 64'd2);
            last_cyc = cyc;
            n++;
         end
         @(negedge clk);
      end
      chk("rr.count", 64'(n), 64'd8);
      repeat (3) @(negedge clk);

      // Reset mid-burst on FIFO1 after 2 of 4 pops.
      for (int k = 0; k < 4; k++)
         push_a(2'd1, 64'hD0 + 64'(k));
      repeat (3) @(negedge clk);
      #1;
      chk("mid.vld",  64'(ifa.out_valid), 64'h1);
      chk("mid.data", ifa.out_data,        64'hD1);
      push_a(2'd0, 64'hE0);
      rst_n = 1'b0;
      #1;
      chk("mrst.vld",  64'(ifa.out_valid), 64'h0);
      chk("mrst.ren",  64'(ifa.fifo_ren),  64'h0);
      chk("mrst.busy", 64'(ifa.busy),      64'h0);
      chk("mrst.data", ifa.out_data,        64'h0);
      @(negedge clk);
      chk("mrst.fifo1_left", 64'(wp_a[1] - rp_a[1]), 64'd2);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("mrst.first_grant", 64'(ifa.fifo_ren), 64'b0001);
      @(negedge clk);
      #1;
      chk("mrst.e0_vld",  64'(ifa.out_valid), 64'h1);
      chk("mrst.e0_data", ifa.out_data,        64'hE0);
      chk("mrst.e0_src",  64'(ifa.out_src),   64'h0);
      n = 0;
      for (int cyc = 0; cyc < 20 && n < 2; cyc++) begin
         @(negedge clk);
         #1;
         if (ifa.out_valid) begin
            chk($sformatf("mrst.rest[%0d]", n), ifa.out_data, 64'hD2 + 64'(n));
            chk($sformatf("mrst.rsrc[%0d]", n), 64'(ifa.out_src), 64'h1);
            n++;
         end
      end
      chk("mrst.rest_count", 64'(n), 64'd2);
      repeat (3) @(negedge clk);

`ifdef CR_FIFO_RR_ARB_STATS_EN
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      chk("stats.clr0", 64'(stall_a), 64'h0);
      push_a(2'd1, 64'hF0);
      push_a(2'd1, 64'hF1);
      ifa.out_ready = 1'b0;
      repeat (9) @(negedge clk);
      chk("stats.stall7", 64'(stall_a), 64'd7);
      ifa.out_ready = 1'b1;
      repeat (6) @(negedge clk);
      chk("stats.stall_hold", 64'(stall_a), 64'd7);
      chk("stats.pop1", 64'(popc_a[31:16]), 64'd2);
      chk("stats.pop0", 64'(popc_a[15:0]), 64'd0);
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      chk("stats.stall_clr", 64'(stall_a), 64'h0);
      chk("stats.pop_clr",   popc_a,        64'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cr_fifo_rr_arb.md
Name: cr_fifo_rr_arb

Overview:
- Round-robin scheduler that drains N_REQ show-ahead request FIFOs into one shared output stream.
- Each FIFO is a cr_fifo_wrap3-style queue. The FIFOs are instantiated outside this block; this block owns their ren.
- Grants are burst-limited (MAX_BURST pops per grant) to bound per-requester latency.
- The output is a single registered valid/ready stage feeding the shared downstream engine.

Parameters:
- N_REQ, 4: number of requester FIFOs; legal range 1..16.
- N_DATA_BITS, 64: width of each FIFO entry and of out_data.
- MAX_BURST, 4: maximum consecutive pops per grant; legal range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- fifo_empty  in  N_REQ  per-FIFO empty flag; bit i belongs to FIFO i
- fifo_rdata  in  N_REQ*N_DATA_BITS  per-FIFO head data (show-ahead); slice i is [i*N_DATA_BITS +: N_DATA_BITS]
- fifo_ren  out  N_REQ  per-FIFO pop strobe; one-hot or zero
- out_valid  out  1  output register holds valid data
- out_data  out  N_DATA_BITS  popped entry
- out_src  out  max(1,$clog2(N_REQ))  index of the FIFO that supplied out_data
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid & out_ready
- busy  out  1  state is BURST or out_valid=1

Behaviour:
- Reset values: state=IDLE; grant=0; last pointer=N_REQ-1, so requester 0 is favoured first. fifo_ren=0, out_valid=0, out_data=0, out_src=0, busy=0.
- slot_free = ~out_valid | out_ready.
- IDLE state:
  - If any fifo_empty bit is 0, pick the first non-empty index searching upward from last+1, wrapping modulo N_REQ.
  - Register that index as grant, clear burst_cnt, go to BURST.
  - fifo_ren is always 0 in IDLE.
- BURST state:
  - fifo_ren[grant] = ~fifo_empty[grant] & slot_free. This is combinational and never asserted while empty, so the arbiter can never cause a FIFO underflow.
  - On a pop: out_data <= fifo_rdata[grant], out_src <= grant, out_valid <= 1, burst_cnt++.
  - Leave BURST for IDLE and set last <= grant when either condition holds:
    - (a) a pop occurs and burst_cnt == MAX_BURST-1;
    - (b) fifo_empty[grant]=1.
  - If slot_free=0 and the FIFO is non-empty, stay in BURST with no pop (stall); burst_cnt holds.
- Output register: when out_valid & out_ready and there is no pop in the same cycle, out_valid <= 0. When a transfer and a pop occur in the same cycle, out_valid stays 1 with the new data, giving full throughput.
- Latency: a FIFO going non-empty at edge t is granted at t+1. Its ren is high during cycle t+1. Its data appears on out_data at t+2.
- Per-grant throughput: up to MAX_BURST entries on consecutive cycles. There is one IDLE bubble cycle between grants.
- Fairness: every non-empty requester is granted within N_REQ-1 other grants.
- N_REQ=1: grant is always 0. The block still returns to IDLE after each burst (bubble every MAX_BURST pops).
- MAX_BURST=1: exactly one pop per grant.
- out_data and out_src hold their values while out_valid=0 or while stalled.
- Reset asserted mid-burst: immediate return to reset values. Any entry held in the output register is dropped; FIFO contents are untouched.

Optional Feature:
- Macro CR_FIFO_RR_ARB_STATS_EN.
- When defined:
  - Adds output stall_cnt [15:0]: counts cycles with out_valid & ~out_ready, saturating at 16'hFFFF.
  - Adds output pop_cnt [N_REQ*16-1:0]: per-requester pop counters, each saturating at 16'hFFFF.
  - Adds input stats_clr: synchronous clear of all counters, taking priority over increment.
  - All counters reset to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, all FIFOs empty, 20 cycles -> fifo_ren=0, out_valid=0, busy=0 throughout.
- FIFO0 holds 6 entries (0xA0..0xA5), others empty, out_ready=1, MAX_BURST=4 -> required sequence:
  - 0xA0..0xA3 on 4 consecutive cycles with out_src=0;
  - one bubble cycle;
  - 0xA4, 0xA5;
  - then IDLE.
- FIFOs 0..3 each hold 2 entries, MAX_BURST=1 -> out_src order 0,1,2,3,0,1,2,3, with one bubble between grants.
- FIFO2 holds 3 entries, out_ready=0 for 5 cycles after the first pop -> exactly 1 pop occurs; out_data is held stable; fifo_ren=0 while stalled. After out_ready=1, the remaining 2 entries follow back-to-back.
- Assert rst_n low mid-burst on FIFO1 (2 of 4 popped) -> out_valid=0 and fifo_ren=0 immediately. After release, requester 0 is granted first if non-empty.
- STATS_EN build: 7 stall cycles followed by stats_clr -> stall_cnt reads 7, then 0 on the cycle after clear. pop_cnt[1] equals the number of FIFO1 pops.
